// File: rtl/oh_fork3_branch.sv
// One fork group: tracks whether the held item still owes this group a delivery
// and arbitrates between the group's two consumers.
module oh_fork3_branch (
  input  logic       clk,
  input  logic       nreset,
  input  logic       full,
  input  logic       load,
  input  logic [1:0] ready,
  output logic [1:0] valid,
  output logic [1:0] take,
  output logic       fire,
  output logic       pend_next
);

  logic pend;
  logic rr;
  logic tie;
  logic win;

  // Tie goes to the member that did not win the previous tie.
  always_comb begin
    tie       = &ready;
    win       = tie ? ~rr : ready[1];
    fire      = full & pend & (|ready);
    take      = 2'b00;
    if (fire) take = win ? 2'b10 : 2'b01;
    pend_next = pend & ~fire;
    valid     = {2{full & pend}};
  end

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      pend <= 1'b0;
      rr   <= 1'b0;
    end else begin
      pend <= load | pend_next;
      if (fire & tie) rr <= win;
    end
  end

endmodule

// File: rtl/oh_fork3.sv
// Eager 3-way fork: one held item is delivered to each of groups A, B and C,
// where either of a group's two members may take it.
module oh_fork3 #(
  parameter int unsigned DW   = 32,
  parameter              PROP = "DEFAULT"
) (
  input  logic          clk,
  input  logic          nreset,
  input  logic          in_valid,
  input  logic [DW-1:0] in_data,
  output logic          in_ready,
  output logic [DW-1:0] out_data,
  output logic [1:0]    a_valid,
  input  logic [1:0]    a_ready,
  output logic [1:0]    a_take,
  output logic [1:0]    b_valid,
  input  logic [1:0]    b_ready,
  output logic [1:0]    b_take,
  output logic [1:0]    c_valid,
  input  logic [1:0]    c_ready,
  output logic [1:0]    c_take,
  output logic          busy
);

  localparam int unsigned NGRP = 3;
  localparam int unsigned NMEM = 2;

  // PROP is an implementation hint carried for interface compatibility only.
  if (PROP == "DEFAULT") begin : g_prop_default
  end

  logic                       full;
  logic [DW-1:0]              data;
  logic                       last;
  logic                       accept;
  logic [NGRP-1:0][NMEM-1:0]  rdy;
  logic [NGRP-1:0][NMEM-1:0]  vld;
  logic [NGRP-1:0][NMEM-1:0]  tk;
  logic [NGRP-1:0]            fire;
  logic [NGRP-1:0]            pend_next;

  assign rdy = {c_ready, b_ready, a_ready};

  for (genvar g = 0; g < NGRP; g++) begin : g_branch
    oh_fork3_branch u_branch (
      .clk       (clk),
      .nreset    (nreset),
      .full      (full),
      .load      (accept),
      .ready     (rdy[g]),
      .valid     (vld[g]),
      .take      (tk[g]),
      .fire      (fire[g]),
      .pend_next (pend_next[g])
    );
  end

  // The item retires once every group is served or being served this cycle.
  always_comb begin
    last     = full & ~(|pend_next);
    in_ready = ~full | last;
    accept   = in_valid & in_ready;
  end

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      full <= 1'b0;
      data <= '0;
    end else begin
      if (accept) begin
        full <= 1'b1;
        data <= in_data;
      end else if (last) begin
        full <= 1'b0;
      end
    end
  end

  assign out_data = data;
  assign busy     = full;
  assign a_valid  = vld[0];
  assign b_valid  = vld[1];
  assign c_valid  = vld[2];
  assign a_take   = tk[0];
  assign b_take   = tk[1];
  assign c_take   = tk[2];

endmodule

// File: tb/tb_oh_fork3.sv
// Self-checking bench for oh_fork3: directed scenarios plus randomized traffic
// compared every cycle against an item-level reference model.
module tb_oh_fork3;

  localparam int unsigned DW = 32;

  logic          clk = 1'b0;
  logic          nreset = 1'b0;
  logic          in_valid = 1'b0;
  logic [DW-1:0] in_data = '0;
  logic          in_ready;
  logic [DW-1:0] out_data;
  logic [1:0]    rdy [3];
  logic [1:0]    vld [3];
  logic [1:0]    tk  [3];
  logic          busy;

  int n_cmp = 0;
  int n_bad = 0;

  oh_fork3 #(.DW(DW), .PROP("DEFAULT")) dut (
    .clk(clk), .nreset(nreset),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .out_data(out_data),
    .a_valid(vld[0]), .a_ready(rdy[0]), .a_take(tk[0]),
    .b_valid(vld[1]), .b_ready(rdy[1]), .b_take(tk[1]),
    .c_valid(vld[2]), .c_ready(rdy[2]), .c_take(tk[2]),
    .busy(busy)
  );

  always #5 clk = ~clk;

  // Reference model: the held item, which groups still owe a delivery,
  // and which member won each group's most recent tie.
  bit          m_full;
  logic [31:0] m_data;
  bit          m_owed [3];
  int          m_last_win [3];

  bit          e_fire [3];
  logic [1:0]  e_take [3];
  int          e_win  [3];
  bit          e_last;
  bit          e_in_ready;

  always_comb begin
    int remaining;
    remaining = 0;
    for (int g = 0; g < 3; g++) begin
      e_fire[g] = m_full && m_owed[g] && (rdy[g] != 2'b00);
      e_win[g]  = 0;
      e_take[g] = 2'b00;
      if (e_fire[g]) begin
        if (rdy[g] == 2'b11) e_win[g] = 1 - m_last_win[g];
        else                 e_win[g] = (rdy[g] == 2'b10) ? 1 : 0;
        e_take[g] = 2'(1 << e_win[g]);
      end
      if (m_full && m_owed[g] && !e_fire[g]) remaining++;
    end
    e_last     = m_full && (remaining == 0);
    e_in_ready = !m_full || e_last;
  end

  always @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      m_full <= 1'b0;
      m_data <= '0;
      for (int g = 0; g < 3; g++) begin
        m_owed[g]     <= 1'b0;
        m_last_win[g] <= 0;
      end
    end else begin
      for (int g = 0; g < 3; g++)
        if (e_fire[g] && rdy[g] == 2'b11) m_last_win[g] <= e_win[g];
      if (in_valid && e_in_ready) begin
        m_full <= 1'b1;
        m_data <= in_data;
        for (int g = 0; g < 3; g++) m_owed[g] <= 1'b1;
      end else if (e_last) begin
        m_full <= 1'b0;
        for (int g = 0; g < 3; g++) m_owed[g] <= 1'b0;
      end else begin
        for (int g = 0; g < 3; g++) if (e_fire[g]) m_owed[g] <= 1'b0;
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Every cycle: all outputs against the model.
  always @(negedge clk) begin
    chk("model in_ready", 32'(in_ready), 32'(e_in_ready));
    chk("model busy", 32'(busy), 32'(m_full));
    chk("model out_data", out_data, m_data);
    for (int g = 0; g < 3; g++) begin
      chk($sformatf("model valid[%0d]", g), 32'(vld[g]), 32'({2{m_full && m_owed[g]}}));
      chk($sformatf("model take[%0d]", g), 32'(tk[g]), 32'(e_take[g]));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_rdy(input logic [1:0] a, input logic [1:0] b, input logic [1:0] c);
    rdy[0] = a;
    rdy[1] = b;
    rdy[2] = c;
  endtask

  initial begin
    set_rdy(2'b00, 2'b00, 2'b00);

    // Reset state with a pending producer
    in_valid = 1'b1;
    in_data  = 32'hDEAD;
    @(negedge clk);
    chk("rst in_ready", 32'(in_ready), 32'd1);
    chk("rst busy", 32'(busy), 32'd0);
    chk("rst out_data", out_data, 32'd0);
    chk("rst a_valid", 32'(vld[0]), 32'd0);
    chk("rst c_take", 32'(tk[2]), 32'd0);
    tick();
    in_valid = 1'b0;
    nreset   = 1'b1;
    tick();

    // Streaming: one item per cycle, ties alternate starting at member 1
    set_rdy(2'b11, 2'b11, 2'b11);
    for (int i = 0; i <= 8; i++) begin
      in_valid = (i < 8);
      in_data  = 32'(i + 1);
      @(negedge clk);
      chk("stream in_ready", 32'(in_ready), 32'd1);
      if (i > 0) begin
        chk("stream out_data", out_data, 32'(i));
        chk("stream a_take", 32'(tk[0]), (i % 2 == 1) ? 32'h2 : 32'h1);
      end
      tick();
    end
    @(negedge clk);
    chk("stream drained busy", 32'(busy), 32'd0);
    tick();

    // Staggered service of 0xCAFE
    set_rdy(2'b00, 2'b00, 2'b00);
    in_valid = 1'b1;
    in_data  = 32'hCAFE;
    tick();
    in_valid = 1'b0;
    set_rdy(2'b01, 2'b00, 2'b00);
    @(negedge clk);
    chk("stagger a_take c1", 32'(tk[0]), 32'h1);
    chk("stagger in_ready c1", 32'(in_ready), 32'd0);
    tick();
    set_rdy(2'b00, 2'b00, 2'b00);
    @(negedge clk);
    chk("stagger a_valid c2", 32'(vld[0]), 32'h0);
    chk("stagger b_valid c2", 32'(vld[1]), 32'h3);
    tick();
    set_rdy(2'b00, 2'b10, 2'b00);
    @(negedge clk);
    chk("stagger b_take c3", 32'(tk[1]), 32'h2);
    tick();
    set_rdy(2'b00, 2'b00, 2'b00);
    @(negedge clk);
    chk("stagger b_valid c4", 32'(vld[1]), 32'h0);
    chk("stagger in_ready c4", 32'(in_ready), 32'd0);
    tick();
    set_rdy(2'b00, 2'b00, 2'b01);
    @(negedge clk);
    chk("stagger in_ready c5", 32'(in_ready), 32'd1);
    chk("stagger out_data c5", out_data, 32'hCAFE);
    tick();
    set_rdy(2'b00, 2'b00, 2'b00);
    @(negedge clk);
    chk("stagger busy c6", 32'(busy), 32'd0);
    tick();

    // Member select: single ready leaves the tie pointer alone
    in_valid = 1'b1;
    in_data  = 32'h11;
    tick();
    in_data  = 32'h22;
    set_rdy(2'b11, 2'b10, 2'b11);
    @(negedge clk);
    chk("select single b_take", 32'(tk[1]), 32'h2);
    tick();
    in_valid = 1'b0;
    set_rdy(2'b11, 2'b11, 2'b11);
    @(negedge clk);
    chk("select tie b_take", 32'(tk[1]), 32'h2);
    chk("select out_data", out_data, 32'h22);
    tick();
    set_rdy(2'b00, 2'b00, 2'b00);
    tick();

    // Backpressure from group C
    in_valid = 1'b1;
    in_data  = 32'h77;
    tick();
    in_data  = 32'h55;
    set_rdy(2'b11, 2'b11, 2'b00);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chk("bp in_ready", 32'(in_ready), 32'd0);
      chk("bp out_data", out_data, 32'h77);
      tick();
    end
    set_rdy(2'b11, 2'b11, 2'b01);
    @(negedge clk);
    chk("bp release in_ready", 32'(in_ready), 32'd1);
    tick();
    in_valid = 1'b0;
    set_rdy(2'b00, 2'b00, 2'b00);
    @(negedge clk);
    chk("bp loaded out_data", out_data, 32'h55);
    chk("bp loaded c_valid", 32'(vld[2]), 32'h3);
    tick();
    set_rdy(2'b11, 2'b11, 2'b11);
    tick();
    set_rdy(2'b00, 2'b00, 2'b00);

    // Mid-operation reset
    in_valid = 1'b1;
    in_data  = 32'h66;
    tick();
    in_valid = 1'b0;
    set_rdy(2'b01, 2'b00, 2'b00);
    tick();
    set_rdy(2'b00, 2'b00, 2'b00);
    #1 nreset = 1'b0;
    #1;
    chk("midrst b_valid", 32'(vld[1]), 32'h0);
    chk("midrst c_valid", 32'(vld[2]), 32'h0);
    chk("midrst busy", 32'(busy), 32'd0);
    tick();
    nreset   = 1'b1;
    in_valid = 1'b1;
    in_data  = 32'h99;
    tick();
    in_valid = 1'b0;
    @(negedge clk);
    chk("midrst fresh a_valid", 32'(vld[0]), 32'h3);
    chk("midrst fresh b_valid", 32'(vld[1]), 32'h3);
    chk("midrst fresh out_data", out_data, 32'h99);
    tick();

    // Randomized traffic with occasional resets
    for (int i = 0; i < 3000; i++) begin
      in_valid = ($urandom_range(0, 3) != 0);
      in_data  = $urandom;
      for (int g = 0; g < 3; g++)
        rdy[g] = ($urandom_range(0, 2) == 0) ? 2'b00 : 2'($urandom);
      nreset = ($urandom_range(0, 199) != 0);
      tick();
    end
    nreset = 1'b1;
    in_valid = 1'b0;
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
